// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: sync polarity levels and
// standard mode presets that instantiation sites unpack into parameters.
package video_timing_pkg;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    typedef struct packed {
        int unsigned h_visible;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_visible;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
        bit          hsync_pol;
        bit          vsync_pol;
    } timing_preset_t;

    localparam timing_preset_t PRESET_VGA_640X480_60 = '{
        h_visible: 640,  h_front: 16,  h_sync: 96, h_back: 48,
        v_visible: 480,  v_front: 10,  v_sync: 2,  v_back: 33,
        hsync_pol: POL_LOW,  vsync_pol: POL_LOW
    };

    localparam timing_preset_t PRESET_720P60 = '{
        h_visible: 1280, h_front: 110, h_sync: 40, h_back: 220,
        v_visible: 720,  v_front: 5,   v_sync: 5,  v_back: 20,
        hsync_pol: POL_HIGH, vsync_pol: POL_HIGH
    };

    localparam timing_preset_t PRESET_1080P60 = '{
        h_visible: 1920, h_front: 88,  h_sync: 44, h_back: 148,
        v_visible: 1080, v_front: 4,   v_sync: 5,  v_back: 36,
        hsync_pol: POL_HIGH, vsync_pol: POL_HIGH
    };

    function automatic int unsigned preset_h_total(input timing_preset_t p);
        return p.h_visible + p.h_front + p.h_sync + p.h_back;
    endfunction

    function automatic int unsigned preset_v_total(input timing_preset_t p);
        return p.v_visible + p.v_front + p.v_sync + p.v_back;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Generic modulo-N counter with count enable, clear and terminal-count carry.
module video_timing_counter #(
    parameter int unsigned N     = 800,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    // Carry is gated by enable so it can directly cascade into the next stage.
    assign carry = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= carry ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/video_timing_generator.sv
// Parametrised raster timing generator (hsync/vsync/de/coordinates/strobes).
// Optional test pattern output out_data is enabled by VIDEO_TIMING_PATTERN_EN.
module video_timing_generator
    import video_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = POL_LOW,
    parameter bit          VSYNC_POL = POL_LOW,
    parameter int unsigned H_WIDTH   = 12,
    parameter int unsigned V_WIDTH   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de,
    output logic [H_WIDTH-1:0] out_x,
    output logic [V_WIDTH-1:0] out_y,
    output logic               out_line_start,
    output logic               out_frame_start
`ifdef VIDEO_TIMING_PATTERN_EN
    ,
    output logic [23:0]        out_data
`endif
);

    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_HS_END   = H_HS_START + H_SYNC;
    localparam int unsigned V_VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_VS_END   = V_VS_START + V_SYNC;

    generate
        if (H_SYNC < 1 || V_SYNC < 1 || H_VISIBLE < 1 || V_VISIBLE < 1) begin : g_bad_params
            $error("video_timing_generator: H_SYNC, V_SYNC, H_VISIBLE and V_VISIBLE must be >= 1");
        end
    endgenerate

    logic [H_WIDTH-1:0] h;
    logic [V_WIDTH-1:0] v;
    logic               h_carry;

    // Dropping enable clears both stages so the next run starts at the origin.
    video_timing_counter #(
        .N     (H_TOTAL),
        .WIDTH (H_WIDTH)
    ) u_h_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (~enable),
        .enable (enable),
        .count  (h),
        .carry  (h_carry)
    );

    video_timing_counter #(
        .N     (V_TOTAL),
        .WIDTH (V_WIDTH)
    ) u_v_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (~enable),
        .enable (h_carry),
        .count  (v),
        .carry  ()
    );

    logic hs_active;
    logic vs_active;
    logic de;

    always_comb begin
        hs_active = (32'(h) >= H_HS_START) && (32'(h) < H_HS_END);
        vs_active = (32'(v) >= V_VS_START) && (32'(v) < V_VS_END);
        de        = (32'(h) < H_VISIBLE) && (32'(v) < V_VISIBLE);
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            out_hsync       <= ~HSYNC_POL;
            out_vsync       <= ~VSYNC_POL;
            out_de          <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
            out_line_start  <= 1'b0;
            out_frame_start <= 1'b0;
        end else begin
            out_hsync       <= hs_active ? HSYNC_POL : ~HSYNC_POL;
            out_vsync       <= vs_active ? VSYNC_POL : ~VSYNC_POL;
            out_de          <= de;
            out_x           <= de ? h : '0;
            out_y           <= de ? v : '0;
            out_line_start  <= (h == '0);
            out_frame_start <= (h == '0) && (v == '0);
        end
    end

`ifdef VIDEO_TIMING_PATTERN_EN
    logic [7:0] x8;
    logic [7:0] y8;

    always_comb begin
        x8 = 8'(h);
        y8 = 8'(v);
    end

    always_ff @(posedge clk) begin
        if (reset || !enable || !de) begin
            out_data <= '0;
        end else begin
            out_data <= {x8, y8, x8 ^ y8};
        end
    end
`endif

endmodule
